log_normalizer: RTL

Upstream pre-processing stage for the logarithm core. It accepts a W-bit unsigned integer and finds its leading one by sequential left shifts. It produces a normalized mantissa x in [1,2) (format 1.f, N fraction bits) and an integer exponent such that value = x * 2^exp. The mantissa feeds the logarithm core's x input; the exponent goes downstream, where it is added to the core's fractional result.

---
 rtl/log_normalizer_if.sv | 26 ++
 rtl/log_normalizer.sv | 85 ++++++++
 2 files changed

// File: rtl/log_normalizer_if.sv
// Operand/result handshake bundle for the log normalizer.
// The master side supplies operands and consumes results; the slave side is the normalizer.
interface log_normalizer_if #(
    parameter int W = 16,
    parameter int N = 8,
    parameter int E = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [0:N]   x;
    logic [E-1:0] exp;
    logic         zero_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, x, exp, zero_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, x, exp, zero_err
    );
endinterface

// File: rtl/log_normalizer.sv
// Leading-one normalizer: turns an unsigned integer into a 1.f mantissa and an exponent
// by shifting left one bit per cycle until the MSB is set.
module log_normalizer #(
    parameter int W = 16,
    parameter int N = 8,
    parameter int E = 4
) (
    input  logic             clk,
    input  logic             reset,
    log_normalizer_if.slave  bus
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t       state;
    logic [W-1:0] sreg;
    logic [CW-1:0] cnt;
    logic [N:0]   mant;

    // Top N+1 bits of the shift register; narrow operands are zero-padded on the right.
    generate
        if (W >= N + 1) begin : g_trunc
            assign mant = sreg[W-1 -: N+1];
        end else begin : g_pad
            assign mant = {sreg, {(N + 1 - W){1'b0}}};
        end
    endgenerate

    // NOTE: in_ready is decoded from state alone so it never depends on in_valid,
    // which keeps the handshake free of combinational loops with the producer.
    assign bus.in_ready = (state == IDLE) & ~reset;

    // NOTE: every register is cleared by the asynchronous reset, so an operation in
    // flight is abandoned the moment reset rises rather than at the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            sreg          <= '0;
            cnt           <= '0;
            bus.x         <= '0;
            bus.exp       <= '0;
            bus.zero_err  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg  <= bus.in_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sreg[W-1]) begin
                        bus.x         <= mant;
                        bus.exp       <= E'(MAX_CNT - cnt);
                        bus.zero_err  <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end else if (sreg == '0) begin
                        // Zero operand: one pass through SHIFT gives it the same
                        // single-cycle latency as an operand with its MSB set.
                        bus.x         <= '0;
                        bus.exp       <= '0;
                        bus.zero_err  <= 1'b1;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        sreg <= sreg << 1;
                        cnt  <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
